// File: rtl/ps2_keyboard_decoder_pkg.sv
// Scancode constants, decoder states and shift_state bit positions for the PS/2 set-2 decoder.
// Shared by the frame receiver and the decoder top; no logic of its own.
package ps2_keyboard_decoder_pkg;

  localparam logic [7:0] SC_E0      = 8'hE0;
  localparam logic [7:0] SC_E1      = 8'hE1;
  localparam logic [7:0] SC_F0      = 8'hF0;
  localparam logic [7:0] SC_LSHIFT  = 8'h12;
  localparam logic [7:0] SC_RSHIFT  = 8'h59;
  localparam logic [7:0] SC_CTRL    = 8'h14;
  localparam logic [7:0] SC_ALT     = 8'h11;
  localparam logic [7:0] SC_F7      = 8'h83;
  localparam logic [6:0] KC_F7_REMAP = 7'h02;

  // Bytes that follow E1 in the Pause make sequence.
  localparam logic [2:0] E1_SKIP_BYTES = 3'd7;

  localparam int SS_SHIFT = 3;
  localparam int SS_CTRL  = 2;
  localparam int SS_ALT   = 1;
  localparam int SS_EXT   = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXT    = 3'd1,
    ST_BRK    = 3'd2,
    ST_EXTBRK = 3'd3,
    ST_SKIP   = 3'd4
  } dec_state_t;

  // Keyboard status/acknowledge bytes that never carry a key.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_keyboard_decoder_if.sv
// PS/2 pin inputs and the decoded key-event stream; master = decoder, slave = pins/consumer side.
// Events are single-cycle strobes with no backpressure.
interface ps2_keyboard_decoder_if;

  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       keypress;
  logic [6:0] keycode;
  logic [3:0] shift_state;
  logic       frame_error;

  modport master (
    input  ps2_clk_in,
    input  ps2_data_in,
    output keypress,
    output keycode,
    output shift_state,
    output frame_error
  );

  modport slave (
    output ps2_clk_in,
    output ps2_data_in,
    input  keypress,
    input  keycode,
    input  shift_state,
    input  frame_error
  );

endinterface

// File: rtl/ps2_keyboard_decoder_rx_frame.sv
// PS/2 frame receiver: pin sync, clock glitch filter, 11-bit shifter, framing/parity check, timeout.
// rx_valid/rx_error pulse the cycle after the accepted stop-bit edge; the keyboard cannot be stalled.
module ps2_keyboard_decoder_rx_frame #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_s;
  logic                   data_s;

  logic                   clk_filt;
  logic [FW-1:0]          filt_cnt;
  logic                   fall;
  logic                   data_bit;

  logic [3:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   par_bit;
  logic [TW-1:0]          idle_cnt;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // Idle PS/2 lines float high, so the synchronizers reset to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
    end
  end

  // A level change is accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
      data_bit <= 1'b1;
    end else begin
      fall <= 1'b0;
      if (clk_s == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s;
        filt_cnt <= '0;
        fall     <= clk_filt;
        data_bit <= data_s;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      idle_cnt <= '0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
      rx_error <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        case (bit_cnt)
          4'd0: begin
            if (!data_bit) begin
              bit_cnt <= 4'd1;
            end else begin
              rx_error <= 1'b1;
            end
          end
          4'd9: begin
            par_bit <= data_bit;
            bit_cnt <= 4'd10;
          end
          4'd10: begin
            bit_cnt <= '0;
            // Odd parity: data plus parity bit must hold an odd number of ones.
            if (data_bit && (^{shreg, par_bit})) begin
              rx_valid <= 1'b1;
              rx_byte  <= shreg;
            end else begin
              rx_error <= 1'b1;
            end
          end
          default: begin
            shreg   <= {data_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
        endcase
      end else if (bit_cnt != 4'd0) begin
        if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
          rx_error <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// PS/2 set-2 decoder: strips E0/F0/E1 prefixes, tracks modifiers, one keypress per make; event 1 cycle after byte.
// No backpressure. PS2_REPEAT_FILTER_EN suppresses auto-repeat makes of the currently held key.
module ps2_keyboard_decoder
  import ps2_keyboard_decoder_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  ps2_keyboard_decoder_if.master bus
);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_error;

  ps2_keyboard_decoder_rx_frame #(
    .SYNC_STAGES    (SYNC_STAGES),
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx_frame (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk_in  (bus.ps2_clk_in),
    .ps2_data_in (bus.ps2_data_in),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .rx_error    (rx_error)
  );

  dec_state_t state;
  dec_state_t state_nxt;
  logic [2:0] skip_cnt;
  logic [2:0] skip_nxt;

  logic       byte_ign;
  logic       do_make;
  logic       do_break;
  logic       key_ext;
  logic       hit_lshift;
  logic       hit_rshift;
  logic       hit_lctrl;
  logic       hit_rctrl;
  logic       hit_lalt;
  logic       hit_ralt;
  logic       hit_fake;
  logic       is_mod;
  logic [6:0] key_code;
  logic       emit;

  logic       lshift;
  logic       rshift;
  logic       lctrl;
  logic       rctrl;
  logic       lalt;
  logic       ralt;

  logic       keypress_q;
  logic [6:0] keycode_q;
  logic [3:0] shift_state_q;
  logic       frame_error_q;

  assign byte_ign = is_ignored(rx_byte);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    if (rx_error) begin
      state_nxt = ST_IDLE;
      skip_nxt  = '0;
    end else if (rx_valid) begin
      case (state)
        ST_SKIP: begin
          // Pause sequence bytes are swallowed whatever their value.
          if (skip_cnt <= 3'd1) begin
            state_nxt = ST_IDLE;
            skip_nxt  = '0;
          end else begin
            skip_nxt = skip_cnt - 3'd1;
          end
        end
        ST_IDLE: begin
          if (!byte_ign) begin
            if (rx_byte == SC_E0) begin
              state_nxt = ST_EXT;
            end else if (rx_byte == SC_F0) begin
              state_nxt = ST_BRK;
            end else if (rx_byte == SC_E1) begin
              state_nxt = ST_SKIP;
              skip_nxt  = E1_SKIP_BYTES;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
        ST_EXT: begin
          if (!byte_ign) begin
            state_nxt = (rx_byte == SC_F0) ? ST_EXTBRK : ST_IDLE;
          end
        end
        ST_BRK, ST_EXTBRK: begin
          if (!byte_ign) begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    do_make  = 1'b0;
    do_break = 1'b0;
    key_ext  = 1'b0;
    if (rx_valid && !rx_error && !byte_ign) begin
      case (state)
        ST_IDLE: do_make = (rx_byte != SC_E0) && (rx_byte != SC_F0) && (rx_byte != SC_E1);
        ST_EXT: begin
          do_make = (rx_byte != SC_F0);
          key_ext = 1'b1;
        end
        ST_BRK: do_break = 1'b1;
        ST_EXTBRK: begin
          do_break = 1'b1;
          key_ext  = 1'b1;
        end
        default: ;
      endcase
    end
    hit_lshift = !key_ext && (rx_byte == SC_LSHIFT);
    hit_rshift = !key_ext && (rx_byte == SC_RSHIFT);
    hit_lctrl  = !key_ext && (rx_byte == SC_CTRL);
    hit_rctrl  =  key_ext && (rx_byte == SC_CTRL);
    hit_lalt   = !key_ext && (rx_byte == SC_ALT);
    hit_ralt   =  key_ext && (rx_byte == SC_ALT);
    // E0 12 / E0 59 are synthetic shifts sent around extended keys.
    hit_fake   =  key_ext && ((rx_byte == SC_LSHIFT) || (rx_byte == SC_RSHIFT));
    is_mod     = hit_lshift | hit_rshift | hit_lctrl | hit_rctrl | hit_lalt | hit_ralt | hit_fake;
    key_code   = (rx_byte == SC_F7) ? KC_F7_REMAP : rx_byte[6:0];
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic       hold_vld;
  logic [7:0] hold_key;
  logic       hold_match;

  assign hold_match = hold_vld && (hold_key == {key_ext, key_code});
  assign emit       = do_make && !is_mod && !hold_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_vld <= 1'b0;
      hold_key <= '0;
    end else if (emit) begin
      hold_vld <= 1'b1;
      hold_key <= {key_ext, key_code};
    end else if (do_break && !is_mod && hold_match) begin
      hold_vld <= 1'b0;
    end
  end
`else
  assign emit = do_make && !is_mod;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      lshift        <= 1'b0;
      rshift        <= 1'b0;
      lctrl         <= 1'b0;
      rctrl         <= 1'b0;
      lalt          <= 1'b0;
      ralt          <= 1'b0;
      keypress_q    <= 1'b0;
      keycode_q     <= '0;
      shift_state_q <= '0;
      frame_error_q <= 1'b0;
    end else begin
      keypress_q    <= 1'b0;
      frame_error_q <= rx_error;
      if (do_make || do_break) begin
        if (hit_lshift) lshift <= do_make;
        if (hit_rshift) rshift <= do_make;
        if (hit_lctrl)  lctrl  <= do_make;
        if (hit_rctrl)  rctrl  <= do_make;
        if (hit_lalt)   lalt   <= do_make;
        if (hit_ralt)   ralt   <= do_make;
      end
      if (emit) begin
        keypress_q                <= 1'b1;
        keycode_q                 <= key_code;
        shift_state_q[SS_SHIFT]   <= lshift | rshift;
        shift_state_q[SS_CTRL]    <= lctrl | rctrl;
        shift_state_q[SS_ALT]     <= lalt | ralt;
        shift_state_q[SS_EXT]     <= key_ext;
      end
    end
  end

  assign bus.keypress    = keypress_q;
  assign bus.keycode     = keycode_q;
  assign bus.shift_state = shift_state_q;
  assign bus.frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Directed bench: bit-bangs PS/2 frames into the decoder and checks the key-event stream.
module tb_ps2_keyboard_decoder;

  localparam int HALF = 15;
  localparam int TO   = 1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ps2_keyboard_decoder_if bus();

  ps2_keyboard_decoder #(
    .SYNC_STAGES    (2),
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         checks = 0;
  int         errors = 0;
  int         kp_cnt = 0;
  int         fe_cnt = 0;
  int         k0 = 0;
  int         f0 = 0;
  logic [6:0] last_kc = '0;
  logic [3:0] last_ss = '0;

  // Counts keypress cycles (so one event == exactly one high cycle) and error pulses.
  always @(negedge clk) begin
    if (bus.keypress === 1'b1) begin
      kp_cnt  <= kp_cnt + 1;
      last_kc <= bus.keycode;
      last_ss <= bus.shift_state;
    end
    if (bus.frame_error === 1'b1) fe_cnt <= fe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data_in = fr[i];
      repeat (HALF) @(posedge clk);
      bus.ps2_clk_in = 1'b0;
      repeat (HALF) @(posedge clk);
      bus.ps2_clk_in = 1'b1;
    end
    bus.ps2_data_in = 1'b1;
    repeat (40) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(b, 1'b0, 11);
  endtask

  task automatic mark();
    @(negedge clk);
    k0 = kp_cnt;
    f0 = fe_cnt;
  endtask

  initial begin
    bus.ps2_clk_in  = 1'b1;
    bus.ps2_data_in = 1'b1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_kp", 32'(bus.keypress), 0);
    check("rst_kc", 32'(bus.keycode), 0);
    check("rst_ss", 32'(bus.shift_state), 0);
    check("rst_fe", 32'(bus.frame_error), 0);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // Plain make.
    mark(); send(8'h1C);
    check("t1_kp", kp_cnt - k0, 1);
    check("t1_kc", 32'(last_kc), 32'h1C);
    check("t1_ss", 32'(last_ss), 32'h0);
    check("t1_fe", fe_cnt - f0, 0);
    send(8'hF0); send(8'h1C);

    // Shifted key, then shift released.
    mark(); send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    check("t2_kp", kp_cnt - k0, 1);
    check("t2_kc", 32'(last_kc), 32'h1C);
    check("t2_ss", 32'(last_ss), 32'h8);
    mark(); send(8'h1C);
    check("t2b_kp", kp_cnt - k0, 1);
    check("t2b_ss", 32'(last_ss), 32'h0);
    send(8'hF0); send(8'h1C);

    // Extended key, then right ctrl held.
    mark(); send(8'hE0); send(8'h75);
    check("t3_kp", kp_cnt - k0, 1);
    check("t3_kc", 32'(last_kc), 32'h75);
    check("t3_ss", 32'(last_ss), 32'h1);
    send(8'hE0); send(8'hF0); send(8'h75);
    mark(); send(8'hE0); send(8'h14); send(8'h1C);
    check("t3b_kp", kp_cnt - k0, 1);
    check("t3b_kc", 32'(last_kc), 32'h1C);
    check("t3b_ss", 32'(last_ss), 32'h4);
    send(8'hF0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h14);

    // Left alt, ignored status byte, fake shift.
    mark(); send(8'h11); send(8'h2A);
    check("alt_ss", 32'(last_ss), 32'h2);
    check("alt_kc", 32'(last_kc), 32'h2A);
    send(8'hF0); send(8'h2A); send(8'hF0); send(8'h11);
    mark(); send(8'hAA); send(8'hE0); send(8'h12);
    check("ign_kp", kp_cnt - k0, 0);
    mark(); send(8'h1C);
    check("fake_ss", 32'(last_ss), 32'h0);
    send(8'hF0); send(8'h1C);

    // Parity error, then recovery.
    mark(); send_bits(8'h1C, 1'b1, 11);
    check("t4_kp", kp_cnt - k0, 0);
    check("t4_fe", fe_cnt - f0, 1);
    mark(); send(8'h29);
    check("t4b_kc", 32'(last_kc), 32'h29);
    check("t4b_kp", kp_cnt - k0, 1);
    send(8'hF0); send(8'h29);

    // Truncated frame times out.
    mark(); send_bits(8'h29, 1'b0, 5);
    check("t5_pre_fe", fe_cnt - f0, 0);
    repeat (TO + 200) @(posedge clk);
    check("t5_fe", fe_cnt - f0, 1);
    check("t5_kp", kp_cnt - k0, 0);
    mark(); send(8'h29);
    check("t5b_kc", 32'(last_kc), 32'h29);
    check("t5b_fe", fe_cnt - f0, 0);
    send(8'hF0); send(8'h29);

    // Pause sequence is swallowed; F7 remap.
    mark();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    check("t6_kp", kp_cnt - k0, 0);
    mark(); send(8'h83);
    check("t6_kc", 32'(last_kc), 32'h02);
    check("t6_ss", 32'(last_ss), 32'h0);
    send(8'hF0); send(8'h83);

    // Reset mid-frame discards the partial frame.
    send_bits(8'h1C, 1'b0, 4);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    mark(); send(8'h1C);
    check("t6r_kc", 32'(last_kc), 32'h1C);
    check("t6r_kp", kp_cnt - k0, 1);
    check("t6r_fe", fe_cnt - f0, 0);
    send(8'hF0); send(8'h1C);

    // Auto-repeat.
    mark(); send(8'h1C); send(8'h1C);
`ifdef PS2_REPEAT_FILTER_EN
    check("rep_kp", kp_cnt - k0, 1);
`else
    check("rep_kp", kp_cnt - k0, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
